// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/load result inputs, register-file write port and forwarding lookup
// Ports: alu_valid/alu_addr/alu_data (ALU result, always accepted),
//        ld_valid/ld_ready/ld_addr/ld_data (load result handshake),
//        rf_write/rf_addr/rf_data (registered register-file write),
//        fwd_addr/fwd_hit/fwd_data (forwarding lookup).
// Modports: master drives results and lookups, slave is the write-back sequencer.
interface regfile_writeback_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
  logic alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic ld_valid;
  logic ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic rf_write;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] fwd_addr;
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, fwd_addr,
    input ld_ready, rf_write, rf_addr, rf_data, fwd_hit, fwd_data
  );
  modport slave (
    input alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, fwd_addr,
    output ld_ready, rf_write, rf_addr, rf_data, fwd_hit, fwd_data
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: orders ALU and load results into one registered register-file write per cycle
// Ports: clk (rising edge), reset (sync, active high), bus (regfile_writeback_if.slave).
// ALU results win every cycle; loads queue in a DEPTH-entry FIFO drained in idle ALU cycles.
// An accepted ALU write kills queued (and same-cycle) loads to the same register.
// Optional: define WB_FWD_EN to build the combinational forwarding lookup; otherwise fwd_* are 0.
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  regfile_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] v;
  logic [ADDR_W-1:0] a [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic alu_acc, push, pop;
  assign alu_acc = bus.alu_valid && bus.alu_addr != '0;
  assign push = bus.ld_valid && bus.ld_ready;
  assign pop = !alu_acc && cnt != '0;
  assign bus.ld_ready = cnt != (PW+1)'(DEPTH) && !reset;
  // valid bits are cleared on pop so that a set bit always means a live, unkilled entry
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      bus.rf_write <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_acc && a[i] == bus.alu_addr) v[i] <= 1'b0;
      if (pop) begin
        v[rp] <= 1'b0;
        rp <= rp + 1'b1;
      end
      // a same-cycle load counts as older than the ALU write, so it is enqueued killed
      if (push) begin
        v[wp] <= bus.ld_addr != '0 && !(alu_acc && bus.ld_addr == bus.alu_addr);
        a[wp] <= bus.ld_addr;
        d[wp] <= bus.ld_data;
        wp <= wp + 1'b1;
      end
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      bus.rf_write <= alu_acc || (pop && v[rp]);
      if (alu_acc) begin
        bus.rf_addr <= bus.alu_addr;
        bus.rf_data <= bus.alu_data;
      end else if (pop) begin
        bus.rf_addr <= a[rp];
        bus.rf_data <= d[rp];
      end
    end
  end
`ifdef WB_FWD_EN
  logic [PW-1:0] idx;
  // later assignments override earlier ones: output register, then FIFO oldest to newest, then ALU input
  always_comb begin
    bus.fwd_hit = 1'b0;
    bus.fwd_data = '0;
    idx = rp;
    if (bus.fwd_addr != '0) begin
      if (bus.rf_write && bus.rf_addr == bus.fwd_addr) begin
        bus.fwd_hit = 1'b1;
        bus.fwd_data = bus.rf_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rp + PW'(k);
        if (v[idx] && a[idx] == bus.fwd_addr) begin
          bus.fwd_hit = 1'b1;
          bus.fwd_data = d[idx];
        end
      end
      if (bus.alu_valid && bus.alu_addr == bus.fwd_addr) begin
        bus.fwd_hit = 1'b1;
        bus.fwd_data = bus.alu_data;
      end
    end
  end
`else
  assign bus.fwd_hit = 1'b0;
  assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed plus random stimulus checked against a queue-based write-back model
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  typedef struct {logic [3:0] a; logic [15:0] d; bit v;} ent_t;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  ent_t q[$];
  bit ew;
  logic [3:0] ea;
  logic [15:0] ed;
  regfile_writeback_if #(.DATA_W(16), .ADDR_W(4)) bus();
  regfile_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(bit r, bit av, logic [3:0] aa, logic [15:0] ad,
                      bit lv, logic [3:0] la, logic [15:0] ldd, logic [3:0] fa);
    bit acc, push, rdy, fh;
    logic [15:0] fd;
    ent_t e;
    reset = r;
    bus.alu_valid = av;
    bus.alu_addr = aa;
    bus.alu_data = ad;
    bus.ld_valid = lv;
    bus.ld_addr = la;
    bus.ld_data = ldd;
    bus.fwd_addr = fa;
    #1;
    rdy = !r && q.size() != DEPTH;
    check("ld_ready", bus.ld_ready, rdy);
    fh = 0;
    fd = 0;
`ifdef WB_FWD_EN
    if (fa != 0) begin
      if (av && aa == fa) begin
        fh = 1;
        fd = ad;
      end else begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (!fh && q[i].v && q[i].a == fa) begin
            fh = 1;
            fd = q[i].d;
          end
        if (!fh && ew && ea == fa) begin
          fh = 1;
          fd = ed;
        end
      end
    end
`endif
    check("fwd_hit", bus.fwd_hit, fh);
    check("fwd_data", bus.fwd_data, fd);
    if (r) begin
      q.delete();
      ew = 0;
      ea = 0;
      ed = 0;
    end else begin
      acc = av && aa != 0;
      push = lv && rdy;
      if (acc) begin
        foreach (q[i]) if (q[i].a == aa) q[i].v = 0;
        ew = 1;
        ea = aa;
        ed = ad;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        ew = e.v;
        ea = e.a;
        ed = e.d;
      end else ew = 0;
      if (push) q.push_back('{a: la, d: ldd, v: (la != 0 && !(acc && la == aa))});
    end
    @(posedge clk);
    #1;
    check("rf_write", bus.rf_write, ew);
    if (ew || r) begin
      check("rf_addr", bus.rf_addr, ea);
      check("rf_data", bus.rf_data, ed);
    end
    @(negedge clk);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    ew = 0;
    ea = 0;
    ed = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 16'h1111, 1, 4, 16'h2222, 0);
    idle(2);
    step(0, 1, 3, 16'hBEEF, 0, 0, 0, 3);
    idle(2);
    step(0, 0, 0, 0, 1, 5, 16'h1234, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5);
    idle(1);
    step(0, 1, 7, 16'h7777, 1, 5, 16'h1234, 5);
    idle(3);
    for (int i = 0; i < 6; i++)
      step(0, 1, 4'(i + 1), 16'(16'hA000 + i), 1, 4'(i + 8), 16'(16'hC000 + i), 4'(i + 8));
    idle(6);
    step(0, 0, 0, 0, 1, 2, 16'h0001, 2);
    step(0, 1, 2, 16'h0002, 0, 0, 0, 2);
    idle(3);
    step(0, 1, 0, 16'h5555, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h6666, 0);
    idle(3);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'(i), 1, 4'(i + 3), 16'(16'hD000 + i), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 9, 16'h9999, 1, 4, 16'hAAAA, 4);
    step(0, 1, 9, 16'h9998, 1, 4, 16'hBBBB, 4);
    step(0, 1, 9, 16'h9997, 0, 0, 0, 4);
    idle(4);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 5)), 16'($urandom),
           $urandom_range(0, 9) < 6, 4'($urandom_range(0, 5)), 16'($urandom), 4'($urandom_range(0, 5)));
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
